// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory port arbiter: bus widths, reset and enable
// levels, sequencer state and port-owner encodings.
package mem_port_arbiter_pkg;

  localparam int unsigned InstAddrBus = 16;
  localparam int unsigned InstBus     = 16;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        ChipEnable = 1'b1;
  localparam logic [15:0] ZeroWord   = 16'h0000;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAccess,
    ArbDone
  } arb_state_e;

  typedef enum logic {
    OwnerIf,
    OwnerMem
  } owner_e;

endpackage

// File: rtl/arb_perf_counter.sv
// 16-bit saturating event counter with synchronous clear (built only with ARB_PERF_EN).
`ifdef ARB_PERF_EN
module arb_perf_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM with a wait-state sequencer and stall request.
// Define ARB_PERF_EN to add the perf_stall_cnt / perf_ifblk_cnt saturating counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = InstAddrBus,
  parameter int unsigned DATA_W      = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stallreq,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_ifblk_cnt
`endif
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant, last;
  logic              ram_ce_d, ram_we_d, if_ready_d, mem_ready_d;
  logic [ADDR_W-2:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d, if_inst_d, mem_rdata_d;
  logic              unused_addr_lsb;

  // Byte addresses are halfword aligned; bit 0 carries no information.
  assign unused_addr_lsb = if_addr[0] ^ mem_addr[0];

  assign grant = (state_q == ArbIdle) && (mem_ce || if_ce);
  assign last  = (state_q == ArbAccess) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= ArbIdle;
      owner_q   <= OwnerIf;
      cnt_q     <= '0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= DATA_W'(ZeroWord);
      if_inst   <= DATA_W'(ZeroWord);
      mem_rdata <= DATA_W'(ZeroWord);
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      ram_ce    <= ram_ce_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      if_inst   <= if_inst_d;
      mem_rdata <= mem_rdata_d;
      if_ready  <= if_ready_d;
      mem_ready <= mem_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (mem_ce || if_ce) begin
          state_d = ArbAccess;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ArbAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = ArbDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // No grant from DONE, so a requester still holding ce is not served twice.
      ArbDone: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    ram_ce_d    = ram_ce;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    if_inst_d   = if_inst;
    mem_rdata_d = mem_rdata;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if (grant) begin
      ram_ce_d = ChipEnable;
      if (mem_ce) begin
        owner_d     = OwnerMem;
        ram_we_d    = mem_we;
        ram_addr_d  = mem_addr[ADDR_W-1:1];
        ram_wdata_d = mem_wdata;
      end else begin
        owner_d     = OwnerIf;
        ram_we_d    = 1'b0;
        ram_addr_d  = if_addr[ADDR_W-1:1];
        ram_wdata_d = '0;
      end
    end
    if (last) begin
      ram_ce_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      if (owner_q == OwnerIf) begin
        if_inst_d  = ram_rdata;
        if_ready_d = 1'b1;
      end else begin
        if (!ram_we) begin
          mem_rdata_d = ram_rdata;
        end
        mem_ready_d = 1'b1;
      end
    end
  end

  assign stallreq = (mem_ce & ~mem_ready) | (if_ce & ~if_ready);

`ifdef ARB_PERF_EN
  logic mem_owns;
  assign mem_owns = (state_q != ArbIdle) && (owner_q == OwnerMem);

  arb_perf_counter u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stallreq),
    .count (perf_stall_cnt)
  );

  arb_perf_counter u_ifblk_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (if_ce & mem_owns),
    .count (perf_ifblk_cnt)
  );
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance with WAIT_CYCLES=1, one with 0,
// each with its own memory model; expectations come from transaction-level timing rules.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_ce, mem_ce, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata;
  logic        use_w0;

  logic        a_if_ready, a_mem_ready, a_stallreq, a_ram_ce, a_ram_we;
  logic [15:0] a_if_inst, a_mem_rdata, a_ram_wdata, a_ram_rdata;
  logic [14:0] a_ram_addr;
  logic        b_if_ready, b_mem_ready, b_stallreq, b_ram_ce, b_ram_we;
  logic [15:0] b_if_inst, b_mem_rdata, b_ram_wdata, b_ram_rdata;
  logic [14:0] b_ram_addr;
`ifdef ARB_PERF_EN
  logic [15:0] a_perf_stall, a_perf_ifblk, b_perf_stall, b_perf_ifblk;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [15:0] init_val(input logic [14:0] w);
    case (w)
      15'd0:   return 16'h0169;
      15'd2:   return 16'h2141;
      15'd8:   return 16'h0B71;
      default: return {w, 1'b0} ^ 16'h3C5A;
    endcase
  endfunction

  logic [15:0] a_mem [0:32767];
  bit          a_wr  [0:32767];
  logic [15:0] b_mem [0:32767];
  bit          b_wr  [0:32767];
  assign a_ram_rdata = a_wr[a_ram_addr] ? a_mem[a_ram_addr] : init_val(a_ram_addr);
  assign b_ram_rdata = b_wr[b_ram_addr] ? b_mem[b_ram_addr] : init_val(b_ram_addr);
  always @(posedge clk) begin
    if (a_ram_ce && a_ram_we) begin
      a_mem[a_ram_addr] <= a_ram_wdata;
      a_wr[a_ram_addr]  <= 1'b1;
    end
    if (b_ram_ce && b_ram_we) begin
      b_mem[b_ram_addr] <= b_ram_wdata;
      b_wr[b_ram_addr]  <= 1'b1;
    end
  end

  mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) u_dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .if_ce     (if_ce & ~use_w0),
    .if_addr   (if_addr),
    .if_inst   (a_if_inst),
    .if_ready  (a_if_ready),
    .mem_ce    (mem_ce & ~use_w0),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (a_mem_rdata),
    .mem_ready (a_mem_ready),
    .stallreq  (a_stallreq),
    .ram_ce    (a_ram_ce),
    .ram_we    (a_ram_we),
    .ram_addr  (a_ram_addr),
    .ram_wdata (a_ram_wdata),
    .ram_rdata (a_ram_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_stall_cnt (a_perf_stall),
    .perf_ifblk_cnt (a_perf_ifblk)
`endif
  );

  mem_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16), .DATA_W(16)) u_dut_w0 (
    .clk       (clk),
    .rst       (rst),
    .if_ce     (if_ce & use_w0),
    .if_addr   (if_addr),
    .if_inst   (b_if_inst),
    .if_ready  (b_if_ready),
    .mem_ce    (mem_ce & use_w0),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (b_mem_rdata),
    .mem_ready (b_mem_ready),
    .stallreq  (b_stallreq),
    .ram_ce    (b_ram_ce),
    .ram_we    (b_ram_we),
    .ram_addr  (b_ram_addr),
    .ram_wdata (b_ram_wdata),
    .ram_rdata (b_ram_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_stall_cnt (b_perf_stall),
    .perf_ifblk_cnt (b_perf_ifblk)
`endif
  );

  // View of whichever instance is currently under test.
  logic        o_if_ready, o_mem_ready, o_stallreq, o_ram_ce, o_ram_we;
  logic [15:0] o_if_inst, o_mem_rdata, o_ram_wdata;
  logic [14:0] o_ram_addr;
  assign o_if_ready  = use_w0 ? b_if_ready  : a_if_ready;
  assign o_mem_ready = use_w0 ? b_mem_ready : a_mem_ready;
  assign o_stallreq  = use_w0 ? b_stallreq  : a_stallreq;
  assign o_ram_ce    = use_w0 ? b_ram_ce    : a_ram_ce;
  assign o_ram_we    = use_w0 ? b_ram_we    : a_ram_we;
  assign o_if_inst   = use_w0 ? b_if_inst   : a_if_inst;
  assign o_mem_rdata = use_w0 ? b_mem_rdata : a_mem_rdata;
  assign o_ram_wdata = use_w0 ? b_ram_wdata : a_ram_wdata;
  assign o_ram_addr  = use_w0 ? b_ram_addr  : a_ram_addr;

  // Reference state: memory image and data registers, per instance.
  logic [15:0] ref_mem  [0:1][0:32767];
  bit          ref_wr   [0:1][0:32767];
  logic [15:0] exp_inst [0:1];
  logic [15:0] exp_rd   [0:1];

  function automatic logic [15:0] ref_word(input int s, input logic [14:0] w);
    return ref_wr[s][w] ? ref_mem[s][w] : init_val(w);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exp_inst[0] = '0; exp_inst[1] = '0;
    exp_rd[0]   = '0; exp_rd[1]   = '0;
  endtask

  // One transaction (fetch, data access, or both at once) on the selected instance.
  // mem wins the port; each service occupies WAIT+3 cycles and readies in its cycle WAIT+2.
  task automatic run_txn(input bit do_if, input bit do_mem, input bit we,
                         input logic [15:0] ia, input logic [15:0] ma, input logic [15:0] wd);
    int s, w, if_t, mem_t, we_cnt, ce_cnt;
    logic [14:0] first_word;
    bit exp_stall;
    s = use_w0 ? 1 : 0;
    w = use_w0 ? 0 : 1;
    mem_t = do_mem ? w + 2 : -1;
    if_t  = do_if ? (do_mem ? 2 * (w + 3) - 1 : w + 2) : -1;
    first_word = do_mem ? ma[15:1] : ia[15:1];
    if_addr = ia; mem_addr = ma; mem_we = we; mem_wdata = wd;
    we_cnt = 0; ce_cnt = 0;
    for (int c = 0; c <= 2 * w + 8; c++) begin
      if_ce  = do_if && (c <= if_t);
      mem_ce = do_mem && (c <= mem_t);
      @(negedge clk);
      if (c == mem_t) begin
        if (we) begin
          ref_mem[s][ma[15:1]] = wd;
          ref_wr[s][ma[15:1]]  = 1'b1;
        end else begin
          exp_rd[s] = ref_word(s, ma[15:1]);
        end
      end
      if (c == if_t) exp_inst[s] = ref_word(s, ia[15:1]);
      exp_stall = (mem_ce && c != mem_t) || (if_ce && c != if_t);
      n_cmp += 5;
      if (o_if_ready !== (c == if_t)) begin
        n_fail++; $display("FAIL if_ready c%0d: got %b want %b", c, o_if_ready, c == if_t);
      end
      if (o_mem_ready !== (c == mem_t)) begin
        n_fail++; $display("FAIL mem_ready c%0d: got %b want %b", c, o_mem_ready, c == mem_t);
      end
      if (o_stallreq !== exp_stall) begin
        n_fail++; $display("FAIL stallreq c%0d: got %b want %b", c, o_stallreq, exp_stall);
      end
      if (o_if_inst !== exp_inst[s]) begin
        n_fail++; $display("FAIL if_inst c%0d: got %h want %h", c, o_if_inst, exp_inst[s]);
      end
      if (o_mem_rdata !== exp_rd[s]) begin
        n_fail++; $display("FAIL mem_rdata c%0d: got %h want %h", c, o_mem_rdata, exp_rd[s]);
      end
      if (c == 0) begin
        n_cmp++;
        if (o_ram_ce !== 1'b0 || o_ram_addr !== 15'h0) begin
          n_fail++; $display("FAIL idle_ram c0: got ce=%b addr=%h want 0/0", o_ram_ce, o_ram_addr);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (o_ram_ce !== 1'b1 || o_ram_addr !== first_word) begin
          n_fail++;
          $display("FAIL access_ram c1: got ce=%b addr=%h want 1/%h", o_ram_ce, o_ram_addr,
                   first_word);
        end
      end
      we_cnt += int'(o_ram_we);
      ce_cnt += int'(o_ram_ce);
      next_cycle();
    end
    if_ce = 1'b0; mem_ce = 1'b0;
    n_cmp += 2;
    if (we_cnt != ((do_mem && we) ? w + 1 : 0)) begin
      n_fail++; $display("FAIL ram_we_cycles: got %0d want %0d", we_cnt, (do_mem && we) ? w + 1 : 0);
    end
    if (ce_cnt != (int'(do_if) + int'(do_mem)) * (w + 1)) begin
      n_fail++;
      $display("FAIL ram_ce_cycles: got %0d want %0d", ce_cnt,
               (int'(do_if) + int'(do_mem)) * (w + 1));
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      use_w0 = (s == 1);
      @(negedge clk);
      n_cmp += 3;
      if ({o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata} !== 33'h0) begin
        n_fail++; $display("FAIL reset_ram s%0d: got %h want 0", s,
                           {o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata});
      end
      if ({o_if_inst, o_mem_rdata} !== 32'h0) begin
        n_fail++; $display("FAIL reset_data s%0d: got %h want 0", s, {o_if_inst, o_mem_rdata});
      end
      if ({o_if_ready, o_mem_ready, o_stallreq} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags s%0d: got %b want 000", s,
                           {o_if_ready, o_mem_ready, o_stallreq});
      end
      next_cycle();
    end
  endtask

  task automatic test_fetch();
    use_w0 = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000);
    n_cmp++;
    if (o_if_inst !== 16'h2141) begin
      n_fail++; $display("FAIL fetch_word2: got %h want 2141", o_if_inst);
    end
  endtask

  task automatic test_simultaneous();
    use_w0 = 1'b0;
    run_txn(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000);
    n_cmp++;
    if ({o_mem_rdata, o_if_inst} !== {16'h0B71, 16'h0169}) begin
      n_fail++; $display("FAIL simul_data: got %h/%h want 0b71/0169", o_mem_rdata, o_if_inst);
    end
  endtask

  task automatic test_store_load();
    use_w0 = 1'b0;
    run_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'hBEEF);
    n_cmp++;
    if (o_mem_rdata !== 16'h0B71) begin
      n_fail++; $display("FAIL store_keeps_rdata: got %h want 0b71", o_mem_rdata);
    end
    run_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0021, 16'h0000);
    n_cmp++;
    if (o_mem_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL load_after_store: got %h want beef", o_mem_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    use_w0 = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000);
    if_addr = 16'h0006; if_ce = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (o_ram_ce !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_in_access: got ram_ce=%b want 1", o_ram_ce);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; if_ce = 1'b0;
    exp_inst[0] = '0; exp_rd[0] = '0;
    @(negedge clk);
    n_cmp++;
    if ({o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata, o_if_inst, o_mem_rdata,
         o_if_ready, o_mem_ready, o_stallreq} !== 68'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got ce=%b addr=%h inst=%h rdy=%b want all 0",
                         o_ram_ce, o_ram_addr, o_if_inst, o_if_ready);
    end
    next_cycle();
    run_txn(1'b1, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000);
  endtask

  task automatic test_held_ce();
    logic [15:0] addrs [0:2];
    int nrdy;
    bit exp_rdy;
    addrs = '{16'h0100, 16'h0102, 16'h0105};
    use_w0 = 1'b1;
    do_reset();
    nrdy = 0;
    for (int c = 0; c < 12; c++) begin
      if_ce   = (c < 9);
      if_addr = addrs[(c < 9) ? c / 3 : 2];
      @(negedge clk);
      exp_rdy = (c < 9) && (c % 3 == 2);
      if (exp_rdy) exp_inst[1] = ref_word(1, addrs[c / 3][15:1]);
      nrdy += int'(o_if_ready);
      n_cmp += 3;
      if (o_if_ready !== exp_rdy) begin
        n_fail++; $display("FAIL held_ready c%0d: got %b want %b", c, o_if_ready, exp_rdy);
      end
      if (o_if_inst !== exp_inst[1]) begin
        n_fail++; $display("FAIL held_inst c%0d: got %h want %h", c, o_if_inst, exp_inst[1]);
      end
      if (o_stallreq !== (if_ce && !exp_rdy)) begin
        n_fail++; $display("FAIL held_stall c%0d: got %b want %b", c, o_stallreq, if_ce && !exp_rdy);
      end
      if (c < 9 && c % 3 == 1) begin
        n_cmp++;
        if (o_ram_ce !== 1'b1 || o_ram_addr !== addrs[c / 3][15:1]) begin
          n_fail++; $display("FAIL held_access c%0d: got ce=%b addr=%h want 1/%h", c, o_ram_ce,
                             o_ram_addr, addrs[c / 3][15:1]);
        end
      end
      next_cycle();
    end
    if_ce = 1'b0;
    n_cmp++;
    if (nrdy != 3) begin
      n_fail++; $display("FAIL held_ready_count: got %0d want 3", nrdy);
    end
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 2; s++) begin
      use_w0 = (s == 1);
      run_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFE, 16'hA55A);
      run_txn(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000);
      n_cmp++;
      if (o_if_inst !== 16'hA55A) begin
        n_fail++; $display("FAIL wrap_fetch s%0d: got %h want a55a", s, o_if_inst);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  kind;
    logic [15:0] ia, ma;
    for (int i = 0; i < 40; i++) begin
      use_w0 = 1'($urandom_range(0, 1));
      kind   = 2'($urandom_range(1, 3));
      ia     = 16'($urandom);
      ma     = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ia = {11'h0, ia[4:0]};
      if ($urandom_range(0, 1) == 1) ma = {11'h0, ma[4:0]};
      run_txn(kind[0], kind[1], 1'($urandom_range(0, 1)), ia, ma, 16'($urandom));
    end
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    int n;
    use_w0 = 1'b0;
    do_reset();
    mem_ce = 1'b1; if_ce = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040; if_addr = 16'h0042;
    for (n = 0; n < 20; n++) next_cycle();
    @(negedge clk);
    n_cmp += 2;
    if (a_perf_stall !== 16'd20) begin
      n_fail++; $display("FAIL perf_stall_20: got %0d want 20", a_perf_stall);
    end
    if (a_perf_ifblk !== 16'(n - (n + 3) / 4)) begin
      n_fail++; $display("FAIL perf_ifblk_20: got %0d want %0d", a_perf_ifblk, n - (n + 3) / 4);
    end
    for (int k = 0; k < 70000; k++) next_cycle();
    n = n + 70000;
    @(negedge clk);
    n_cmp += 2;
    if (a_perf_stall !== 16'hFFFF) begin
      n_fail++; $display("FAIL perf_stall_sat: got %h want ffff", a_perf_stall);
    end
    if (a_perf_ifblk !== 16'(n - (n + 3) / 4)) begin
      n_fail++; $display("FAIL perf_ifblk_long: got %0d want %0d", a_perf_ifblk, n - (n + 3) / 4);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({a_perf_stall, a_perf_ifblk} !== 32'h0) begin
      n_fail++; $display("FAIL perf_clear: got %h/%h want 0/0", a_perf_stall, a_perf_ifblk);
    end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    use_w0 = 1'b0; rst = 1'b1;
    if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_load();
    test_reset_mid_access();
    test_held_ce();
    test_wrap();
    test_random();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
